// File: rtl/uvc_vfb_source.sv
// Pixel FIFO between a non-stallable video source and the UVC frame-buffer read port.
// Define UVC_VFB_TESTPATTERN_EN to build the colour-bar generator selected by tp_sel_i.
module uvc_vfb_source #(
  parameter int unsigned FIFO_AW     = 10,
  parameter int unsigned RDY_LEVEL   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned H_ACTIVE    = 640
) (
  input  logic        usb_clk_w,
  input  logic        rst_n,
  input  logic        pix_valid_i,
  input  logic [23:0] pix_data_i,
  input  logic        pix_sof_i,
  input  logic        vfb_vs_i,
  input  logic        vfb_re_i,
  output logic [23:0] vfb_data_o,
  output logic        vfb_rdy_o,
  input  logic        tp_sel_i,
  output logic        ovf_o,
  output logic        udf_o
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] RdyLvl = RDY_LEVEL[FIFO_AW:0];
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [19:0] FrameW = FRAME_WORDS[19:0];

  typedef enum logic [1:0] {StIdle, StSync, StStream, StDone} state_e;

  // Assert asynchronously, release two clocks later.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;
  always_ff @(posedge usb_clk_w or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_e state_q, state_d;
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
  logic [19:0] wcnt_q, wcnt_d;
  logic [23:0] data_q, data_d, wr_data, tp_pix;
  logic ovf_q, ovf_d, udf_q, udf_d, rdy_q, rdy_d;
  logic full, empty, pop, wr_req, wr_en, tp_on, tp_adv;
  logic [FIFO_AW-1:0] wr_addr;
  logic [23:0] mem_q [Depth];

  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

`ifdef UVC_VFB_TESTPATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / 8;
  logic [15:0] tp_col_q;
  logic [2:0]  tp_bar_q;

  assign tp_on = tp_sel_i;

  // Bar index wraps 7 -> 0 at the end of each line.
  always_ff @(posedge usb_clk_w or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tp_col_q <= '0;
      tp_bar_q <= '0;
    end else if (vfb_vs_i) begin
      tp_col_q <= '0;
      tp_bar_q <= '0;
    end else if (tp_adv) begin
      if (tp_col_q == 16'(BarW - 1)) begin
        tp_col_q <= '0;
        tp_bar_q <= tp_bar_q + 3'd1;
      end else begin
        tp_col_q <= tp_col_q + 16'd1;
      end
    end
  end

  always_comb begin
    tp_pix = 24'h000000;
    unique case (tp_bar_q)
      3'd0: tp_pix = 24'hFFFFFF;
      3'd1: tp_pix = 24'hFFFF00;
      3'd2: tp_pix = 24'h00FFFF;
      3'd3: tp_pix = 24'h00FF00;
      3'd4: tp_pix = 24'hFF00FF;
      3'd5: tp_pix = 24'hFF0000;
      3'd6: tp_pix = 24'h0000FF;
      3'd7: tp_pix = 24'h000000;
      default: tp_pix = 24'h000000;
    endcase
  end
`else
  localparam int unsigned unused_h_active = H_ACTIVE;
  logic unused_tp;
  assign tp_on     = 1'b0;
  assign tp_pix    = 24'h000000;
  assign unused_tp = tp_sel_i ^ tp_adv;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    pop     = 1'b0;
    wr_req  = 1'b0;
    wr_en   = 1'b0;
    tp_adv  = 1'b0;
    wr_data = pix_data_i;
    wr_addr = wptr_q[FIFO_AW-1:0];
    if (vfb_vs_i) begin
      state_d = StSync;
      wptr_d  = '0;
      rptr_d  = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      // A frame-start pixel arriving with the flush opens the new frame at once.
      if (pix_valid_i && pix_sof_i && !tp_on) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wptr_d  = PtrOne;
        wcnt_d  = 20'd1;
        state_d = StStream;
      end
    end else begin
      if (vfb_re_i) begin
        if (!empty) begin
          pop    = 1'b1;
          data_d = mem_q[rptr_q[FIFO_AW-1:0]];
          rptr_d = rptr_q + PtrOne;
        end else begin
          data_d = 24'h000000;
          udf_d  = 1'b1;
        end
      end
      rdy_d = (level >= RdyLvl) || ((state_q == StDone) && !empty);
      unique case (state_q)
        StIdle: ;
        StSync: begin
          if (tp_on) begin
            state_d = StStream;
          end else if (pix_valid_i && pix_sof_i) begin
            wr_req  = 1'b1;
            wcnt_d  = 20'd1;
            state_d = StStream;
          end
        end
        StStream: begin
          if (tp_on) begin
            if (!full) begin
              tp_adv  = 1'b1;
              wr_data = tp_pix;
              wr_en   = 1'b1;
              wptr_d  = wptr_q + PtrOne;
              wcnt_d  = wcnt_q + 20'd1;
              if (wcnt_d == FrameW) state_d = StDone;
            end
          end else if (pix_valid_i) begin
            if (pix_sof_i) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              wr_req = 1'b1;
              wcnt_d = wcnt_q + 20'd1;
              if (wcnt_d == FrameW) state_d = StDone;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
      // A same-cycle pop frees the slot, so only a full FIFO without a read drops.
      if (wr_req) begin
        if (full && !pop) begin
          ovf_d = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + PtrOne;
        end
      end
    end
  end

  always_ff @(posedge usb_clk_w or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge usb_clk_w) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign vfb_data_o = data_q;
  assign vfb_rdy_o  = rdy_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

endmodule

// File: tb/tb_uvc_vfb_source.sv
// Directed bench for uvc_vfb_source: stimulus queues expected read data, a monitor
// checks each read one cycle later; flag and ready checks are made inline.
module tb_uvc_vfb_source;

  localparam int unsigned FrameWords = 1500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        vfb_vs = 1'b0;
  logic        vfb_re = 1'b0;
  logic        tp_sel = 1'b0;
  logic [23:0] vfb_data;
  logic        vfb_rdy, ovf, udf;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];

  uvc_vfb_source #(
    .FIFO_AW    (10),
    .RDY_LEVEL  (256),
    .FRAME_WORDS(FrameWords),
    .H_ACTIVE   (640)
  ) dut (
    .usb_clk_w  (clk),
    .rst_n      (rst_n),
    .pix_valid_i(pix_valid),
    .pix_data_i (pix_data),
    .pix_sof_i  (pix_sof),
    .vfb_vs_i   (vfb_vs),
    .vfb_re_i   (vfb_re),
    .vfb_data_o (vfb_data),
    .vfb_rdy_o  (vfb_rdy),
    .tp_sel_i   (tp_sel),
    .ovf_o      (ovf),
    .udf_o      (udf)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at an edge must show its word by the following negedge.
  initial begin
    logic re_s, vs_s;
    logic [23:0] e;
    forever begin
      @(posedge clk);
      re_s = vfb_re;
      vs_s = vfb_vs;
      @(negedge clk);
      if (re_s && !vs_s) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %06h expected no read", vfb_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", vfb_data, e);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic s, input logic [23:0] d, input logic re,
                     input logic vs);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    vfb_re    = re;
    vfb_vs    = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [23:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`ifdef UVC_VFB_TESTPATTERN_EN
    tp_sel = 1'b0;
`else
    tp_sel = 1'b1;  // must be ignored in this build
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", vfb_data, 24'h0);
    check("rst_rdy", {23'd0, vfb_rdy}, 24'd0);
    check("rst_ovf", {23'd0, ovf}, 24'd0);
    check("rst_udf", {23'd0, udf}, 24'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Fill to the ready threshold, then read back in order.
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, i == 0, 24'hA00000 + 24'(i), 1'b0, 1'b0);
      if (i == 255) check("rdy_at_256", {23'd0, vfb_rdy}, 24'd0);
      if (i == 256) check("rdy_after_256", {23'd0, vfb_rdy}, 24'd1);
    end
    for (int k = 0; k < 300; k++) rd(24'hA00000 + 24'(k));
    idle(2);
    check("t1_rdy_empty", {23'd0, vfb_rdy}, 24'd0);
    check("t1_ovf", {23'd0, ovf}, 24'd0);
    check("t1_udf", {23'd0, udf}, 24'd0);

    // Underflow leaves the pointers alone.
    for (int k = 0; k < 3; k++) rd(24'h0);
    check("t2_udf", {23'd0, udf}, 24'd1);
    cyc(1'b1, 1'b0, 24'hB00001, 1'b0, 1'b0);
    rd(24'hB00001);
    check("t2_udf_sticky", {23'd0, udf}, 24'd1);

    // Flush beats a same-cycle read and a non-sof write.
    cyc(1'b1, 1'b0, 24'hC0FFEE, 1'b1, 1'b1);
    check("t3_udf_clr", {23'd0, udf}, 24'd0);
    check("t3_rdy", {23'd0, vfb_rdy}, 24'd0);
    rd(24'h0);
    check("t3_empty_udf", {23'd0, udf}, 24'd1);
    cyc(1'b1, 1'b0, 24'hD00001, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 24'hD00002, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hD00003, 1'b0, 1'b0);
    rd(24'hD00002);
    rd(24'hD00003);
    rd(24'h0);

    // Overflow: 1100 pixels into 1024 words; dropped pixels still count towards the frame.
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b1, i == 0, 24'hE00000 + 24'(i), 1'b0, 1'b0);
      if (i == 1023) check("t4_ovf_at_full", {23'd0, ovf}, 24'd0);
      if (i == 1024) check("t4_ovf_set", {23'd0, ovf}, 24'd1);
    end
    for (int k = 0; k < 1024; k++) rd(24'hE00000 + 24'(k));
    rd(24'h0);
    for (int i = 0; i < 400; i++) cyc(1'b1, 1'b0, 24'hF00000 + 24'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hF0FFFF, 1'b0, 1'b0);
    idle(2);
    check("t4_rdy_400", {23'd0, vfb_rdy}, 24'd1);
    for (int k = 0; k < 200; k++) rd(24'hF00000 + 24'(k));
    idle(1);
    check("t4_rdy_done_low", {23'd0, vfb_rdy}, 24'd1);
    for (int k = 200; k < 400; k++) rd(24'hF00000 + 24'(k));
    idle(2);
    check("t4_rdy_drained", {23'd0, vfb_rdy}, 24'd0);
    rd(24'h0);
    check("t4_ovf_sticky", {23'd0, ovf}, 24'd1);
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    check("t4_ovf_clr", {23'd0, ovf}, 24'd0);
    check("t4_udf_clr", {23'd0, udf}, 24'd0);
    check("t4_rdy_flush", {23'd0, vfb_rdy}, 24'd0);

    // Full frame with concurrent reads holding the level at 300.
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < FrameWords; i++) begin
      if (i >= 300) exp_q.push_back(24'h400000 + 24'(i - 300));
      cyc(1'b1, i == 0, 24'h400000 + 24'(i), i >= 300, 1'b0);
    end
    for (int j = 0; j < 300; j++) begin
      exp_q.push_back(24'h400000 + 24'(FrameWords - 300 + j));
      cyc(j == 0, 1'b0, 24'h4FFFFF, 1'b1, 1'b0);
      check("t5_rdy_done", {23'd0, vfb_rdy}, 24'd1);
    end
    idle(1);
    check("t5_rdy_empty", {23'd0, vfb_rdy}, 24'd0);
    rd(24'h0);
    check("t5_ovf", {23'd0, ovf}, 24'd0);

    // A second sof truncates the frame.
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 24'h111111, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'h222222, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 24'h333333, 1'b0, 1'b0);
    check("t6_ovf_trunc", {23'd0, ovf}, 24'd1);
    cyc(1'b1, 1'b0, 24'h444444, 1'b0, 1'b0);
    idle(1);
    check("t6_rdy_done", {23'd0, vfb_rdy}, 24'd1);
    rd(24'h111111);
    rd(24'h222222);
    idle(1);
    check("t6_data_held", vfb_data, 24'h222222);

    // Asynchronous reset mid-frame.
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_data", vfb_data, 24'h0);
    check("t7_rst_ovf", {23'd0, ovf}, 24'd0);
    check("t7_rst_rdy", {23'd0, vfb_rdy}, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd(24'h0);
    check("t7_udf", {23'd0, udf}, 24'd1);
    cyc(1'b1, 1'b1, 24'h777777, 1'b0, 1'b0);
    rd(24'h0);

`ifdef UVC_VFB_TESTPATTERN_EN
    tp_sel = 1'b1;
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    idle(700);
    for (int k = 0; k < 641; k++) rd(bars[(k % 640) / 80]);
    tp_sel = 1'b0;
`else
    check("bars_unused", bars[7], 24'h000000);
`endif

    idle(3);
    check("exp_q_drained", 24'(exp_q.size()), 24'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
